// File: rtl/linear_layer_fifo_pkg.sv
// linear_layer_fifo_pkg: shared defaults and sizing helper for the Linear_Layer start-token FIFO
package linear_layer_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 1;
  localparam int DEF_ADDR_WIDTH = 1;
  localparam int DEF_DEPTH = 2;
  localparam int CNT_WIDTH = DEF_ADDR_WIDTH + 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/linear_layer_start_fifo_srl.sv
// linear_layer_start_fifo_srl: shift-register token store, new data enters at index 0, read at addr
module linear_layer_start_fifo_srl
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  localparam int N = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [N];
  // Sized to the full address space so any addr is a legal index; slots past DEPTH are never read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < N; i++) mem[i] <= mem[i-1];
    end
  end
  assign dout = mem[addr];
  if (DEPTH > N || DEPTH < 1) begin : g_bad_depth
    $error("linear_layer_start_fifo_srl: DEPTH does not fit ADDR_WIDTH");
  end
endmodule

// File: rtl/linear_layer_start_fifo_ctrl.sv
// linear_layer_start_fifo_ctrl: start-token FIFO controller (occupancy, SRL addressing, handshakes,
// sticky overflow/underflow flags) over an SRL store.
module linear_layer_start_fifo_ctrl
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  clr_err,
  output logic                  ovf_err,
  output logic                  udf_err
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic rdy, push, pop, ovf_hit, udf_hit;
  logic [ADDR_WIDTH-1:0] addr;
  if (clog2(DEPTH) > ADDR_WIDTH) begin : g_bad_addr
    $error("linear_layer_start_fifo_ctrl: ADDR_WIDTH too small for DEPTH");
  end
  // rdy keeps full_n low through reset and releases it on the first edge afterwards.
  always_comb begin
    if_empty_n = count != '0;
    if_full_n = rdy && count != FULL;
    push = if_write && if_write_ce && if_full_n;
    pop = if_read && if_read_ce && if_empty_n;
    ovf_hit = if_write && if_write_ce && count == FULL;
    udf_hit = if_read && if_read_ce && !if_empty_n;
    addr = if_empty_n ? ADDR_WIDTH'(count - CW'(1)) : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy <= 1'b0;
      count <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      rdy <= 1'b1;
      count <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
      ovf_err <= ovf_hit || (ovf_err && !clr_err);
      udf_err <= udf_hit || (udf_err && !clr_err);
    end
  end
  linear_layer_start_fifo_srl #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH)
  ) u_srl (
    .clk(clk),
    .we(push),
    .addr(addr),
    .din(if_din),
    .dout(if_dout)
  );
endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// tb_linear_layer_start_fifo_ctrl: directed DEPTH=2 checks plus DEPTH=1 random run against a queue model
module tb_linear_layer_start_fifo_ctrl;
  logic clk, reset;
  logic wce_a, wr_a, din_a, rce_a, rd_a, clr_a;
  logic full_n_a, dout_a, empty_n_a, ovf_a, udf_a;
  logic [1:0] count_a;
  logic wce_b, wr_b, din_b, rce_b, rd_b, clr_b;
  logic full_n_b, dout_b, empty_n_b, ovf_b, udf_b;
  logic [1:0] count_b;
  int errors = 0;
  int checks = 0;

  linear_layer_start_fifo_ctrl #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(2)) dut_a (
    .clk(clk), .reset(reset),
    .if_write_ce(wce_a), .if_write(wr_a), .if_din(din_a), .if_full_n(full_n_a),
    .if_read_ce(rce_a), .if_read(rd_a), .if_dout(dout_a), .if_empty_n(empty_n_a),
    .count(count_a), .clr_err(clr_a), .ovf_err(ovf_a), .udf_err(udf_a)
  );
  linear_layer_start_fifo_ctrl #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(1)) dut_b (
    .clk(clk), .reset(reset),
    .if_write_ce(wce_b), .if_write(wr_b), .if_din(din_b), .if_full_n(full_n_b),
    .if_read_ce(rce_b), .if_read(rd_b), .if_dout(dout_b), .if_empty_n(empty_n_b),
    .count(count_b), .clr_err(clr_b), .ovf_err(ovf_b), .udf_err(udf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit q[$];
    bit m_ovf, m_udf, push, pop;
    reset = 1'b1;
    {wce_a, wr_a, din_a, rce_a, rd_a, clr_a} = '0;
    {wce_b, wr_b, din_b, rce_b, rd_b, clr_b} = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_full_n", full_n_a, 0);
    check("rst_empty_n", empty_n_a, 0);
    check("rst_count", count_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_udf", udf_a, 0);
    reset = 1'b0;
    tick();
    check("rel_full_n", full_n_a, 1);
    check("rel_empty_n", empty_n_a, 0);
    // fill with 1 then 0
    wce_a = 1; rce_a = 1; wr_a = 1; din_a = 1;
    tick();
    check("push1_count", count_a, 1);
    check("push1_empty_n", empty_n_a, 1);
    check("push1_dout", dout_a, 1);
    din_a = 0;
    tick();
    check("push2_count", count_a, 2);
    check("push2_full_n", full_n_a, 0);
    check("push2_dout", dout_a, 1);
    din_a = 1;
    tick();
    check("ovf_flag", ovf_a, 1);
    check("ovf_count", count_a, 2);
    check("ovf_dout", dout_a, 1);
    wr_a = 0; clr_a = 1;
    tick();
    check("clr_ovf", ovf_a, 0);
    clr_a = 0; rd_a = 1;
    tick();
    check("pop1_count", count_a, 1);
    check("pop1_dout", dout_a, 0);
    tick();
    check("pop2_count", count_a, 0);
    check("pop2_empty_n", empty_n_a, 0);
    check("pop2_udf", udf_a, 0);
    // simultaneous push/pop with head=0
    rd_a = 0; wr_a = 1; din_a = 0;
    tick();
    check("pp_pre_dout", dout_a, 0);
    din_a = 1; rd_a = 1;
    tick();
    check("pp_count", count_a, 1);
    check("pp_dout", dout_a, 1);
    wr_a = 0;
    tick();
    check("pp_drain_empty_n", empty_n_a, 0);
    rce_a = 0;
    tick();
    check("udf_ce0", udf_a, 0);
    rce_a = 1;
    tick();
    check("udf_flag", udf_a, 1);
    check("udf_count", count_a, 0);
    clr_a = 1;
    tick();
    check("udf_clr_vs_new", udf_a, 1);
    rd_a = 0;
    tick();
    check("udf_clr", udf_a, 0);
    clr_a = 0; wr_a = 1; wce_a = 0;
    tick();
    check("wce0_count", count_a, 0);
    check("wce0_ovf", ovf_a, 0);
    wce_a = 1;
    repeat (2) tick();
    check("refill_count", count_a, 2);
    wr_a = 0;
    #2 reset = 1'b1;
    #1;
    check("async_count", count_a, 0);
    check("async_empty_n", empty_n_a, 0);
    check("async_full_n", full_n_a, 0);
    reset = 1'b0;
    tick();
    check("async_rel_full_n", full_n_a, 1);
    check("async_rel_count", count_a, 0);
    // DEPTH=1 random run
    m_ovf = 0; m_udf = 0;
    for (int n = 0; n < 10000; n++) begin
      wr_b = 1'($urandom); wce_b = 1'($urandom_range(0, 3) != 0);
      rd_b = 1'($urandom); rce_b = 1'($urandom_range(0, 3) != 0);
      din_b = 1'($urandom);
      push = wr_b && wce_b && q.size() < 1;
      pop = rd_b && rce_b && q.size() > 0;
      m_ovf |= wr_b && wce_b && q.size() == 1;
      m_udf |= rd_b && rce_b && q.size() == 0;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(din_b);
      tick();
      check("rnd_count", count_b, q.size());
      check("rnd_empty_n", empty_n_b, q.size() != 0);
      check("rnd_full_n", full_n_b, q.size() != 1);
      if (q.size() != 0) check("rnd_dout", dout_b, q[0]);
      check("rnd_ovf", ovf_b, m_ovf);
      check("rnd_udf", udf_b, m_udf);
      check("rnd_bound", count_b <= 2'd1, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
